// File: rtl/rle_axil_pkg.sv
// Shared definitions for the RLE_REV2 S00_AXI control-register slave.
//   - AXI response codes
//   - register count and register-index width
//   - write / read handshake state encodings
package rle_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int NUM_REGS  = 4;
   localparam int REG_IDX_W = 2;
   localparam int DATA_W    = 32;
   localparam int STRB_W    = DATA_W / 8;

   typedef enum logic [1:0] {
      W_IDLE   = 2'd0,
      W_GOT_AW = 2'd1,
      W_GOT_W  = 2'd2,
      W_RESP   = 2'd3
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

endpackage

// File: rtl/rle_axil_strb_merge.sv
// Byte-strobe merge for one control register.
//   old_word_i : current register contents
//   wdata_i    : incoming write data
//   wstrb_i    : byte enables, bit i selects byte i of wdata_i
//   new_word_o : merged word (enabled bytes from wdata_i, others held)
module rle_axil_strb_merge
   import rle_axil_pkg::*;
(
   input  logic [DATA_W-1:0] old_word_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [STRB_W-1:0] wstrb_i,
   output logic [DATA_W-1:0] new_word_o
);

   for (genvar b = 0; b < STRB_W; b++) begin : g_byte
      assign new_word_o[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8] : old_word_i[8*b +: 8];
   end

endmodule

// File: rtl/rle_axil_slave_regs.sv
// AXI4-Lite slave holding the four 32-bit RLE_REV2 control registers.
//   S_AXI_*    : AXI4-Lite slave port (single-beat, one write and one read
//                outstanding; AWPROT/ARPROT and ADDR[1:0] are ignored)
//   regs_o     : register contents, reg n at [32n+31:32n]
//   wr_pulse_o : one-cycle strobe per register written
// Build option: define RLE_AXIL_WR_PULSE_EN to build the write-pulse logic;
// otherwise wr_pulse_o is tied to 0.
//
// Write FSM
//   state    | meaning
//   W_IDLE   | AWREADY=WREADY=1, waiting for address and/or data
//   W_GOT_AW | address latched, waiting for data
//   W_GOT_W  | data and strobe latched, waiting for address
//   W_RESP   | write committed, BVALID held until BREADY
// Read FSM
//   state    | meaning
//   R_IDLE   | ARREADY=1, waiting for read address
//   R_DATA   | RDATA captured, RVALID held until RREADY
module rle_axil_slave_regs
   import rle_axil_pkg::*;
#(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 4,
   parameter logic [31:0] C_REG_RESET        = 32'h0
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [NUM_REGS*DATA_W-1:0]        regs_o,
   output logic [NUM_REGS-1:0]               wr_pulse_o
);

   // Readies stay low during reset and come up on the first edge after it.
   logic rdy_en_q;

   wr_state_e              wr_state_d, wr_state_q;
   logic [REG_IDX_W-1:0]   aw_idx_d, aw_idx_q;
   logic [DATA_W-1:0]      wdata_d, wdata_q;
   logic [STRB_W-1:0]      wstrb_d, wstrb_q;
   logic                   aw_hs, w_hs, commit;
   logic [REG_IDX_W-1:0]   wr_idx;
   logic [DATA_W-1:0]      wr_data;
   logic [STRB_W-1:0]      wr_strb;

   rd_state_e              rd_state_d, rd_state_q;
   logic [DATA_W-1:0]      rdata_d, rdata_q;
   logic                   ar_hs;
   logic [REG_IDX_W-1:0]   ar_idx;

   logic [DATA_W-1:0]      regs_d [NUM_REGS];
   logic [DATA_W-1:0]      regs_q [NUM_REGS];
   logic [DATA_W-1:0]      merged [NUM_REGS];

   wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = rdy_en_q && (wr_state_q == W_IDLE || wr_state_q == W_GOT_W);
   assign S_AXI_WREADY  = rdy_en_q && (wr_state_q == W_IDLE || wr_state_q == W_GOT_AW);
   assign S_AXI_BVALID  = (wr_state_q == W_RESP);
   assign S_AXI_BRESP   = RESP_OKAY;

   assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

   // Whichever half arrived earlier comes from its latch, the other from the bus.
   assign wr_idx  = (wr_state_q == W_GOT_AW) ? aw_idx_q : S_AXI_AWADDR[3:2];
   assign wr_data = (wr_state_q == W_GOT_W)  ? wdata_q  : S_AXI_WDATA;
   assign wr_strb = (wr_state_q == W_GOT_W)  ? wstrb_q  : S_AXI_WSTRB;

   always_comb begin
      wr_state_d = wr_state_q;
      aw_idx_d   = aw_idx_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      commit     = 1'b0;
      unique case (wr_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               wr_state_d = W_RESP;
               commit     = 1'b1;
            end else if (aw_hs) begin
               wr_state_d = W_GOT_AW;
               aw_idx_d   = S_AXI_AWADDR[3:2];
            end else if (w_hs) begin
               wr_state_d = W_GOT_W;
               wdata_d    = S_AXI_WDATA;
               wstrb_d    = S_AXI_WSTRB;
            end
         end
         W_GOT_AW: begin
            if (w_hs) begin
               wr_state_d = W_RESP;
               commit     = 1'b1;
            end
         end
         W_GOT_W: begin
            if (aw_hs) begin
               wr_state_d = W_RESP;
               commit     = 1'b1;
            end
         end
         W_RESP: begin
            if (S_AXI_BREADY) wr_state_d = W_IDLE;
         end
         default: wr_state_d = W_IDLE;
      endcase
   end

   for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
      rle_axil_strb_merge u_merge (
         .old_word_i (regs_q[n]),
         .wdata_i    (wr_data),
         .wstrb_i    (wr_strb),
         .new_word_o (merged[n])
      );
      assign regs_d[n] = (commit && wr_idx == REG_IDX_W'(n)) ? merged[n] : regs_q[n];
      assign regs_o[DATA_W*n +: DATA_W] = regs_q[n];
   end

   assign S_AXI_ARREADY = rdy_en_q && (rd_state_q == R_IDLE);
   assign S_AXI_RVALID  = (rd_state_q == R_DATA);
   assign S_AXI_RRESP   = RESP_OKAY;
   assign S_AXI_RDATA   = rdata_q;
   assign ar_hs         = S_AXI_ARVALID && S_AXI_ARREADY;
   assign ar_idx        = S_AXI_ARADDR[3:2];

   // Capture reads from regs_q so a same-edge write returns the old value.
   always_comb begin
      rd_state_d = rd_state_q;
      rdata_d    = rdata_q;
      unique case (rd_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               rd_state_d = R_DATA;
               rdata_d    = regs_q[ar_idx];
            end
         end
         R_DATA: begin
            if (S_AXI_RREADY) rd_state_d = R_IDLE;
         end
         default: rd_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rdy_en_q   <= 1'b0;
         wr_state_q <= W_IDLE;
         aw_idx_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= C_REG_RESET;
      end else begin
         rdy_en_q   <= 1'b1;
         wr_state_q <= wr_state_d;
         aw_idx_q   <= aw_idx_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         rd_state_q <= rd_state_d;
         rdata_q    <= rdata_d;
         for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= regs_d[n];
      end
   end

`ifdef RLE_AXIL_WR_PULSE_EN
   logic [NUM_REGS-1:0] wr_pulse_d, wr_pulse_q;

   always_comb begin
      wr_pulse_d = '0;
      if (commit) wr_pulse_d[wr_idx] = 1'b1;
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) wr_pulse_q <= '0;
      else                wr_pulse_q <= wr_pulse_d;
   end

   assign wr_pulse_o = wr_pulse_q;
`else
   assign wr_pulse_o = '0;
`endif

endmodule

// File: tb/tb_rle_axil_slave_regs.sv
// Self-checking bench for rle_axil_slave_regs. A simple array of four words
// models the register file; strobe merging is done byte by byte.
module tb_rle_axil_slave_regs;

   localparam logic [31:0] RST_VAL = 32'hA5A5_0F0F;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   awaddr = '0;
   logic [2:0]   awprot = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b0;
   logic [3:0]   araddr = '0;
   logic [2:0]   arprot = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b0;
   logic [127:0] regs_o;
   logic [3:0]   wr_pulse_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] model [4];

   always #5 clk = ~clk;

   rle_axil_slave_regs #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (4),
      .C_REG_RESET        (RST_VAL)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .regs_o        (regs_o),
      .wr_pulse_o    (wr_pulse_o)
   );

   function automatic logic [127:0] model_vec();
      return {model[3], model[2], model[1], model[0]};
   endfunction

   function automatic logic [3:0] exp_pulse(input int idx);
`ifdef RLE_AXIL_WR_PULSE_EN
      return 4'(1 << idx);
`else
      return 4'b0000;
`endif
   endfunction

   // Called just after a posedge. aw_dly/w_dly: cycles before each VALID rises.
   // b_hold: cycles BREADY is held low after BVALID appears.
   task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_hold);
      bit aw_done = 0, w_done = 0, aw_fire, w_fire;
      int cyc = 0;
      int idx = int'(a[3:2]);
      while (!(aw_done && w_done) && cyc < 40) begin
         awaddr = a; awprot = 3'($urandom); wdata = d; wstrb = s;
         awvalid = !aw_done && cyc >= aw_dly;
         wvalid  = !w_done && cyc >= w_dly;
         @(negedge clk);
         aw_fire = awvalid && awready;
         w_fire  = wvalid && wready;
         if (aw_done && !w_done) begin
            n_checks++;
            if (awready !== 1'b0) begin
               n_fail++; $display("FAIL wr_got_aw_awready: got %b want 0", awready);
            end
         end
         if (w_done && !aw_done) begin
            n_checks++;
            if (wready !== 1'b0) begin
               n_fail++; $display("FAIL wr_got_w_wready: got %b want 0", wready);
            end
         end
         @(posedge clk); #1;
         aw_done |= aw_fire;
         w_done  |= w_fire;
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      n_checks++;
      if (!(aw_done && w_done)) begin
         n_fail++; $display("FAIL wr_handshake_timeout: aw=%b w=%b want both 1", aw_done, w_done);
         return;
      end
      for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      n_checks++;
      if (bvalid !== 1'b1 || bresp !== 2'b00) begin
         n_fail++; $display("FAIL wr_bresp: bvalid=%b bresp=%b want 1/00", bvalid, bresp);
      end
      n_checks++;
      if (regs_o !== model_vec()) begin
         n_fail++; $display("FAIL wr_regs_o: got %h want %h", regs_o, model_vec());
      end
      n_checks++;
      if (wr_pulse_o !== exp_pulse(idx)) begin
         n_fail++; $display("FAIL wr_pulse: got %b want %b", wr_pulse_o, exp_pulse(idx));
      end
      for (int h = 0; h < b_hold; h++) begin
         awaddr = 4'($urandom); wdata = $urandom; awvalid = 1'b1; wvalid = 1'b1;
         @(negedge clk);
         n_checks++;
         if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_hold: bvalid=%b awready=%b wready=%b want 1/0/0", bvalid, awready, wready);
         end
         @(posedge clk); #1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0;
      n_checks++;
      if (bvalid !== 1'b0 || wr_pulse_o !== 4'b0000 || regs_o !== model_vec()) begin
         n_fail++;
         $display("FAIL wr_after_b: bvalid=%b pulse=%b regs=%h want 0/0000/%h", bvalid, wr_pulse_o, regs_o, model_vec());
      end
   endtask

   // Called just after a posedge. Returns the captured RDATA in got.
   task automatic do_read(input logic [3:0] a, input int r_hold, output logic [31:0] got);
      bit fired = 0;
      int cyc = 0;
      got = 'x;
      while (!fired && cyc < 40) begin
         araddr = a; arprot = 3'($urandom); arvalid = 1'b1;
         @(negedge clk);
         fired = arready;
         @(posedge clk); #1;
         cyc++;
      end
      arvalid = 1'b0;
      n_checks++;
      if (!fired) begin
         n_fail++; $display("FAIL rd_handshake_timeout: arready never 1");
         return;
      end
      n_checks++;
      if (rvalid !== 1'b1 || rresp !== 2'b00) begin
         n_fail++; $display("FAIL rd_rresp: rvalid=%b rresp=%b want 1/00", rvalid, rresp);
      end
      got = rdata;
      for (int h = 0; h < r_hold; h++) begin
         araddr = 4'($urandom); arvalid = 1'b1;
         @(negedge clk);
         n_checks++;
         if (rvalid !== 1'b1 || rdata !== got || arready !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_hold: rvalid=%b rdata=%h arready=%b want 1/%h/0", rvalid, rdata, arready, got);
         end
         @(posedge clk); #1;
      end
      arvalid = 1'b0;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      n_checks++;
      if (rvalid !== 1'b0) begin
         n_fail++; $display("FAIL rd_after_r: rvalid=%b want 0", rvalid);
      end
   endtask

   task automatic check_idle_reset(input string tag);
      n_checks++;
      if (awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0 || bvalid !== 1'b0 ||
          rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0 ||
          regs_o !== {4{RST_VAL}} || wr_pulse_o !== 4'b0000) begin
         n_fail++;
         $display("FAIL %s: rdy=%b%b%b bv=%b rv=%b rdata=%h regs=%h pulse=%b want all reset", tag,
                  awready, wready, arready, bvalid, rvalid, rdata, regs_o, wr_pulse_o);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) model[i] = RST_VAL;
      repeat (3) @(negedge clk);
      check_idle_reset("reset_values");
      #2 rst_n = 1'b1;
      #1;
      n_checks++;
      if (awready !== 1'b0 || arready !== 1'b0) begin
         n_fail++; $display("FAIL ready_before_edge: awready=%b arready=%b want 0/0", awready, arready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
         n_fail++; $display("FAIL ready_after_edge: %b%b%b want 111", awready, wready, arready);
      end
   endtask

   task automatic test_basic_writes();
      logic [31:0] vals [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};
      logic [31:0] got;
      for (int i = 0; i < 4; i++) begin
         do_write(4'(i * 4), vals[i], 4'hF, 0, 0, 0);
         do_read(4'(i * 4) | 4'($urandom_range(0, 3)), 0, got);
         n_checks++;
         if (got !== vals[i]) begin
            n_fail++; $display("FAIL basic_readback[%0d]: got %h want %h", i, got, vals[i]);
         end
      end
   endtask

   task automatic test_strobe();
      logic [31:0] got;
      do_write(4'h4, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      do_write(4'h4, 32'h12345678, 4'b0101, 0, 0, 0);
      do_read(4'h4, 0, got);
      n_checks++;
      if (got !== 32'hFF34FF78) begin
         n_fail++; $display("FAIL strobe_merge: got %h want ff34ff78", got);
      end
      do_write(4'hC, 32'h0, 4'b0000, 0, 0, 0);
      do_read(4'hC, 0, got);
      n_checks++;
      if (got !== model[3]) begin
         n_fail++; $display("FAIL strobe_zero: got %h want %h", got, model[3]);
      end
   endtask

   task automatic test_split();
      logic [31:0] got;
      do_write(4'h8, 32'h0BADF00D, 4'hF, 0, 3, 0);
      do_read(4'h8, 0, got);
      n_checks++;
      if (got !== 32'h0BADF00D) begin
         n_fail++; $display("FAIL aw_first: got %h want 0badf00d", got);
      end
      do_write(4'h0, 32'hCAFE1234, 4'hF, 3, 0, 0);
      do_read(4'h0, 0, got);
      n_checks++;
      if (got !== 32'hCAFE1234) begin
         n_fail++; $display("FAIL w_first: got %h want cafe1234", got);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] got, exp;
      exp = model[1];
      fork
         do_write(4'h0, 32'h600DCAFE, 4'hF, 0, 0, 5);
         do_read(4'h4, 5, got);
      join
      n_checks++;
      if (got !== exp) begin
         n_fail++; $display("FAIL backpressure_rdata: got %h want %h", got, exp);
      end
   endtask

   task automatic test_collision();
      logic [31:0] got, exp_old;
      exp_old = model[2];
      fork
         do_write(4'h8, 32'h55AA55AA, 4'hF, 0, 0, 0);
         do_read(4'h8, 0, got);
      join
      n_checks++;
      if (got !== exp_old) begin
         n_fail++; $display("FAIL collision_old: got %h want %h", got, exp_old);
      end
      do_read(4'h8, 0, got);
      n_checks++;
      if (got !== 32'h55AA55AA) begin
         n_fail++; $display("FAIL collision_new: got %h want 55aa55aa", got);
      end
   endtask

   task automatic test_random();
      logic [31:0] got, d;
      logic [3:0]  a, s;
      for (int i = 0; i < 24; i++) begin
         a = 4'($urandom); d = $urandom; s = 4'($urandom);
         do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         a = 4'($urandom);
         do_read(a, $urandom_range(0, 2), got);
         n_checks++;
         if (got !== model[a[3:2]]) begin
            n_fail++; $display("FAIL random_read[%0d]: got %h want %h", i, got, model[a[3:2]]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] got;
      awaddr = 4'hC; awvalid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (awready !== 1'b1) begin
         n_fail++; $display("FAIL mid_aw_accept: awready=%b want 1", awready);
      end
      @(posedge clk); #1;
      awvalid = 1'b0;
      @(negedge clk);
      n_checks++;
      if (awready !== 1'b0 || wready !== 1'b1) begin
         n_fail++; $display("FAIL mid_got_aw: awready=%b wready=%b want 0/1", awready, wready);
      end
      #2 rst_n = 1'b0;
      for (int i = 0; i < 4; i++) model[i] = RST_VAL;
      #1 check_idle_reset("mid_reset_values");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_checks++;
         if (bvalid !== 1'b0 || wready !== 1'b1 || regs_o !== {4{RST_VAL}}) begin
            n_fail++;
            $display("FAIL mid_dropped[%0d]: bvalid=%b wready=%b regs=%h want 0/1/reset", c, bvalid, wready, regs_o);
         end
      end
      @(posedge clk); #1;
      do_write(4'hC, 32'h13579BDF, 4'hF, 0, 0, 0);
      do_read(4'hC, 0, got);
      n_checks++;
      if (got !== 32'h13579BDF) begin
         n_fail++; $display("FAIL post_reset_write: got %h want 13579bdf", got);
      end
   endtask

   initial begin
      test_reset();
      test_basic_writes();
      test_strobe();
      test_split();
      test_backpressure();
      test_collision();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, want finish");
      $fatal(1, "timeout");
   end

endmodule
